mem_stage: RTL

- Memory stage of the sequential Y86-64 core. It sits between execute and pc_update/write-back.
- Consumes icode, valE, valA and valP for the current instruction and performs the data-memory access.
- Produces valM for decode write-back and pc_update (ret).
- Data memory is a byte-wide array accessed one byte per clock, so every 64-bit access is a multi-cycle transaction under a start/done handshake.

---
 rtl/mem_stage.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the sequential Y86-64 core.
//
// Performs the data-memory access selected by icode. The data memory is a
// byte-wide array. One byte moves per clock, so every 64-bit access is an
// 8-beat transaction under a start/done handshake. The memory uses
// little-endian byte order.
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN - when defined, a memory op whose address has
//                        addr[2:0] != 0 is rejected as an error.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin stage for current instruction (sampled only in IDLE)
//   icode      instruction code from fetch
//   valE       ALU result from execute
//   valA       register operand A from decode
//   valP       incremented PC from fetch
//   ld_en      preload write strobe (honoured only in IDLE)
//   ld_addr    preload byte address (ignored when >= MEM_DEPTH)
//   ld_data    preload byte
//   valM       data read from memory (updated only by completed reads)
//   done       one-cycle completion pulse
//   busy       high while not IDLE
//   dmem_error out-of-range (or misaligned) flag for the completed op
module mem_stage #(
  parameter int unsigned MEM_DEPTH = 8192,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [63:0]       valE,
  input  logic [63:0]       valA,
  input  logic [63:0]       valP,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [63:0]       valM,
  output logic              done,
  output logic              busy,
  output logic              dmem_error
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  // Highest legal byte address, widened by one bit so addr+7 cannot wrap.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Operation latched at the accepting start edge.
  logic [2:0]       cnt;
  logic             op_read;
  logic [IDX_W-1:0] op_addr;
  logic [63:0]      op_wdata;
  logic [63:0]      rd_asm;

  // Decode of the current (unlatched) instruction.
  logic              dec_mem;
  logic              dec_read;
  logic [ADDR_W-1:0] dec_addr;
  logic [63:0]       dec_wdata;
  logic              range_err;
  logic              align_err;
  logic              dec_err;
  logic              accept;

  // Data memory and its single write port.
  logic [7:0]       mem [MEM_DEPTH];
  logic [IDX_W-1:0] acc_idx;
  logic [7:0]       rd_byte;
  logic             ld_ok;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_byte;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  always_comb begin
    dec_mem   = 1'b0;
    dec_read  = 1'b0;
    dec_addr  = ADDR_W'(valE);
    dec_wdata = valA;
    case (icode)
      4'h4: dec_mem = 1'b1;                       // rmmovq
      4'h5: begin                                 // mrmovq
        dec_mem  = 1'b1;
        dec_read = 1'b1;
      end
      4'hA: dec_mem = 1'b1;                       // pushq
      4'hB: begin                                 // popq
        dec_mem  = 1'b1;
        dec_read = 1'b1;
        dec_addr = ADDR_W'(valA);
      end
      4'h8: begin                                 // call
        dec_mem   = 1'b1;
        dec_wdata = valP;
      end
      4'h9: begin                                 // ret
        dec_mem  = 1'b1;
        dec_read = 1'b1;
        dec_addr = ADDR_W'(valA);
      end
      default: ;
    endcase
  end

  always_comb begin
    range_err = ({1'b0, dec_addr} + (ADDR_W+1)'(7)) > LAST_ADDR;
  end

  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    align_err = (dec_addr[2:0] != 3'b000);
`else
    align_err = 1'b0;
`endif
  end

  always_comb begin
    dec_err = dec_mem && (range_err || align_err);
    accept  = (state == IDLE) && start;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (dec_mem && !dec_err) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCESS: begin
        if (cnt == 3'd7) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    done = (state == DONE);
    busy = (state != IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_read    <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      rd_asm     <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= '0;
        op_read    <= dec_read;
        op_addr    <= dec_addr[IDX_W-1:0];
        op_wdata   <= dec_wdata;
        dmem_error <= dec_err;
      end else if (state == ACCESS) begin
        cnt <= cnt + 3'd1;
        // Write data is shifted right so byte cnt is always in [7:0].
        op_wdata <= {8'h00, op_wdata[63:8]};
        // Read bytes enter at the top; after 8 beats byte 0 sits in [7:0].
        rd_asm <= {rd_byte, rd_asm[63:8]};
        if (cnt == 3'd7 && op_read) begin
          valM <= {rd_byte, rd_asm[63:8]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------
  always_comb begin
    acc_idx = op_addr + IDX_W'(cnt);
    rd_byte = mem[acc_idx];
    ld_ok   = ld_addr < ADDR_W'(MEM_DEPTH);
  end

  // Preload (IDLE only) and op writes (ACCESS only) never coincide, so one
  // write port serves both.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_byte = op_wdata[7:0];
    if (state == ACCESS && !op_read) begin
      wr_en = 1'b1;
    end else if (state == IDLE && ld_en && ld_ok) begin
      wr_en   = 1'b1;
      wr_idx  = ld_addr[IDX_W-1:0];
      wr_byte = ld_data;
    end
  end

  // Contents survive reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_idx] <= wr_byte;
    end
  end

endmodule
